// File: rtl/bsarb_pkg.sv
// Shared constants, types and the left-to-right amount conversion for the
// two-requester rotate arbiter.
package bsarb_pkg;

    localparam int DW = 8;
    localparam int KW = 3;

    typedef logic req_id_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // A left rotate by k equals a right rotate by (DW - k); the KW-bit
    // wrap-around makes k = 0 map back to 0.
    function automatic logic [KW-1:0] calc_k_eff(input logic [KW-1:0] k,
                                                 input logic          left);
        logic [KW-1:0] dw_mod;
        dw_mod = KW'(DW);
        return left ? (dw_mod - k) : k;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit combinational right rotator.
module barrel_shifter
    import bsarb_pkg::*;
(
    output logic [DW-1:0] o_y,
    input  logic [DW-1:0] i_a,
    input  logic [KW-1:0] i_k
);

    logic [2*DW-1:0] doubled;

    // Selecting a DW-wide window out of the operand concatenated with itself
    // yields the right rotation directly.
    always_comb begin
        doubled = {i_a, i_a};
        o_y     = doubled[{1'b0, i_k} +: DW];
    end

endmodule

// File: rtl/barrel_shifter_arbiter.sv
// Two requesters share one rotator; the result sits in a one-entry output slot.
// Tie-break is round-robin when BSARB_ROUND_ROBIN_EN is defined, else fixed priority to requester 0.
module barrel_shifter_arbiter
    import bsarb_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic [DW-1:0] i_req0_data,
    input  logic [KW-1:0] i_req0_k,
    input  logic          i_req0_left,
    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    input  logic [DW-1:0] i_req1_data,
    input  logic [KW-1:0] i_req1_k,
    input  logic          i_req1_left,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output req_id_t       o_rsp_id,
    output logic          o_busy
);

    slot_state_t   state_q;
    slot_state_t   state_d;
    logic [DW-1:0] rsp_data_q;
    req_id_t       rsp_id_q;
    req_id_t       winner;
    logic          can_load;
    logic          accept;
    logic [DW-1:0] win_data;
    logic [KW-1:0] win_k;
    logic          win_left;
    logic [KW-1:0] win_k_eff;
    logic [DW-1:0] rot_y;

`ifdef BSARB_ROUND_ROBIN_EN
    req_id_t last_gnt_q;

    always_comb begin
        winner = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            winner = ~last_gnt_q;
        end else if (i_req1_valid) begin
            winner = 1'b1;
        end
    end

    // Reset value 1 hands the first tie to requester 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt_q <= 1'b1;
        end else if (accept) begin
            last_gnt_q <= winner;
        end
    end
`else
    assign winner = !i_req0_valid && i_req1_valid;
`endif

    assign can_load     = (state_q == SLOT_EMPTY) || i_rsp_ready;
    assign o_req0_ready = can_load && (winner == 1'b0) && !i_rst;
    assign o_req1_ready = can_load && (winner == 1'b1) && !i_rst;
    assign accept       = (i_req0_valid && o_req0_ready) ||
                          (i_req1_valid && o_req1_ready);

    always_comb begin
        win_data  = winner ? i_req1_data : i_req0_data;
        win_k     = winner ? i_req1_k    : i_req0_k;
        win_left  = winner ? i_req1_left : i_req0_left;
        win_k_eff = calc_k_eff(win_k, win_left);
    end

    barrel_shifter u_rot (
        .o_y (rot_y),
        .i_a (win_data),
        .i_k (win_k_eff)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A load takes precedence over a drain so both can happen in one cycle.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = SLOT_FULL;
        end else if (i_rsp_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else if (accept) begin
            rsp_data_q <= rot_y;
            rsp_id_q   <= winner;
        end
    end

    assign o_rsp_valid = (state_q == SLOT_FULL);
    assign o_busy      = o_rsp_valid;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Directed self-checking bench for barrel_shifter_arbiter; contention
// expectations follow BSARB_ROUND_ROBIN_EN.
module tb_barrel_shifter_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_left;
    logic [7:0] req0_data;
    logic [2:0] req0_k;
    logic       req1_valid, req1_ready, req1_left;
    logic [7:0] req1_data;
    logic [2:0] req1_k;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    barrel_shifter_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_data  (req0_data),
        .i_req0_k     (req0_k),
        .i_req0_left  (req0_left),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_data  (req1_data),
        .i_req1_k     (req1_k),
        .i_req1_left  (req1_left),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .o_busy       (busy)
    );

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic [2:0] k0, input logic l0,
                                 input logic v1, input logic [7:0] d1,
                                 input logic [2:0] k1, input logic l1,
                                 input logic rr);
        req0_valid = v0; req0_data = d0; req0_k = k0; req0_left = l0;
        req1_valid = v1; req1_data = d1; req1_k = k1; req1_left = l1;
        rsp_ready  = rr;
    endtask

    task automatic test_reset();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid);
        end
        tests_run++;
        if (rsp_data !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h expected 00", rsp_data);
        end
        tests_run++;
        if (rsp_id !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_id_busy: got id=%b busy=%b expected 0 0", rsp_id, busy);
        end
        applyStimulus(1, 8'h11, 3'd1, 0, 1, 8'h22, 3'd1, 0, 1);
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_readies: got %b%b expected 00", req0_ready, req1_ready);
        end
        rst = 1'b0;
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
    endtask

    task automatic test_right_rotate();
        @(negedge clk);
        applyStimulus(1, 8'hB4, 3'd3, 0, 0, 8'h00, 3'd0, 0, 1);
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL right_readies: got %b%b expected 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h96 || rsp_id !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL right_rotate: got v=%b d=%h id=%b expected 1 96 0", rsp_valid, rsp_data, rsp_id);
        end
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h96) begin
            tests_failed++;
            $display("[TB] FAIL right_drain: got v=%b d=%h expected 0 96", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_rotations();
        logic [7:0] t_data [7] = '{8'h81, 8'h5A, 8'h5A, 8'hB4, 8'h01, 8'h80, 8'hF0};
        logic [2:0] t_k    [7] = '{3'd1,  3'd0,  3'd0,  3'd3,  3'd7,  3'd7,  3'd2};
        logic       t_left [7] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        logic [7:0] t_exp  [7] = '{8'h03, 8'h5A, 8'h5A, 8'hA5, 8'h02, 8'h40, 8'hC3};
        logic       t_req  [7] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        for (int i = 0; i < 7; i++) begin
            if (t_req[i])
                applyStimulus(0, 8'h00, 3'd0, 0, 1, t_data[i], t_k[i], t_left[i], 1);
            else
                applyStimulus(1, t_data[i], t_k[i], t_left[i], 0, 8'h00, 3'd0, 0, 1);
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_data !== t_exp[i] || rsp_id !== t_req[i]) begin
                tests_failed++;
                $display("[TB] FAIL rotate_vec%0d: got v=%b d=%h id=%b expected 1 %h %b",
                         i, rsp_valid, rsp_data, rsp_id, t_exp[i], t_req[i]);
            end
        end
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic exp_id;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 8'h11, 3'd1, 0, 1, 8'h0F, 3'd4, 1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef BSARB_ROUND_ROBIN_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id ||
                rsp_data !== (exp_id ? 8'hF0 : 8'h88)) begin
                tests_failed++;
                $display("[TB] FAIL contention_%0d: got v=%b id=%b d=%h expected 1 %b %h",
                         i, rsp_valid, rsp_id, rsp_data, exp_id, exp_id ? 8'hF0 : 8'h88);
            end
        end
        req0_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'hF0) begin
            tests_failed++;
            $display("[TB] FAIL contention_req1_after: got v=%b id=%b d=%h expected 1 1 f0",
                     rsp_valid, rsp_id, rsp_data);
        end
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        applyStimulus(1, 8'hB4, 3'd3, 0, 0, 8'h00, 3'd0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 8'h00, 3'd0, 0, 1, 8'h81, 3'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_data !== 8'h96 || rsp_id !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_hold%0d: got rdy=%b%b v=%b d=%h id=%b expected 00 1 96 0",
                         i, req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_release_ready: got %b expected 1", req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_id !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_reload: got v=%b d=%h id=%b expected 1 03 1",
                     rsp_valid, rsp_data, rsp_id);
        end
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h03 || rsp_id !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_drain: got v=%b d=%h id=%b expected 0 03 1",
                     rsp_valid, rsp_data, rsp_id);
        end
    endtask

    task automatic test_reset_mid_hold();
        applyStimulus(1, 8'hB4, 3'd3, 0, 0, 8'h00, 3'd0, 0, 0);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h96) begin
            tests_failed++;
            $display("[TB] FAIL midreset_load: got v=%b d=%h expected 1 96", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        applyStimulus(1, 8'h11, 3'd1, 0, 1, 8'h0F, 3'd4, 1, 1);
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_readies: got %b%b expected 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_cleared: got v=%b d=%h id=%b busy=%b expected 0 00 0 0",
                     rsp_valid, rsp_data, rsp_id, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h88) begin
            tests_failed++;
            $display("[TB] FAIL midreset_first_grant: got v=%b id=%b d=%h expected 1 0 88",
                     rsp_valid, rsp_id, rsp_data);
        end
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 0);
        repeat (2) @(negedge clk);
        test_reset();
        test_right_rotate();
        test_rotations();
        test_contention();
        test_backpressure();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
